// File: rtl/ch_timing_pkg.sv
// Shared types and defaults for the bit-timing scheduler and its quantum prescaler.
package ch_timing_pkg;

  localparam int PRESC_W_DEFAULT = 8;
  localparam int TQ_W_DEFAULT    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TSEG1 = 2'd2,
    TSEG2 = 2'd3
  } seg_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tq_prescaler.sv
// Time-quantum prescaler: divides clk by presc+1 and flags the last clock of each quantum.
module tq_prescaler
  import ch_timing_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               restart,
  input  logic [PRESC_W-1:0] presc,
  output logic [PRESC_W-1:0] count,
  output logic               tq_tick
);

  logic [PRESC_W-1:0] count_reg;

  assign count   = count_reg;
  assign tq_tick = (count_reg == presc);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_reg <= '0;
    end else if (restart || tq_tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bit_sample_sched.sv
// Bit timing scheduler: walks SYNC/TSEG1/TSEG2 per bit, issues sample strobes,
// votes the sampled bit and performs hard synchronisation on idle-bus falling edges.
module bit_sample_sched
  import ch_timing_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEFAULT,
  parameter int TQ_W    = TQ_W_DEFAULT
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable,
  input  logic [PRESC_W-1:0] cfgPresc,
  input  logic [TQ_W-1:0]    cfgTseg1,
  input  logic [TQ_W-1:0]    cfgTseg2,
  input  logic               rateSelector,
  input  logic               rxIn,
  input  logic               busIdle,
  output logic               samplePulse,
  output logic               bitStart,
  output logic               sampledBit,
  output logic               bitValid,
  output logic               cfgErr
);

  seg_state_t         state_reg, state_next;
  logic [PRESC_W-1:0] presc_reg;
  logic [TQ_W-1:0]    tseg1_reg, tseg2_reg;
  logic               rate_reg;
  logic [TQ_W-1:0]    seg_cnt_reg, seg_cnt_next;
  logic               rx_prev_reg;
  logic [1:0]         samples_reg;
  logic               sampled_bit_reg;
  logic               bit_valid_reg;
  logic               cfg_err_reg;

  logic [PRESC_W-1:0] presc_count;
  logic               tq_tick;
  logic               presc_restart;
  logic               cfg_legal;
  logic               start_bit;
  logic               in_tseg;
  logic               hard_sync;
  logic               tseg1_last;
  logic               tseg2_last;
  logic               in_window;
  logic               final_sample;

  tq_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .resetN  (resetN),
    .restart (presc_restart),
    .presc   (presc_reg),
    .count   (presc_count),
    .tq_tick (tq_tick)
  );

  // Triple sampling needs two quanta before the sample point inside TSEG1.
  assign cfg_legal = (cfgTseg1 != '0) && (cfgTseg2 != '0) &&
                     !(rateSelector && (cfgTseg1 < TQ_W'(3)));

  assign start_bit  = (state_reg == IDLE) && enable && cfg_legal && !cfg_err_reg;
  assign in_tseg    = (state_reg == TSEG1) || (state_reg == TSEG2);
  assign hard_sync  = enable && busIdle && rx_prev_reg && !rxIn && in_tseg;
  assign tseg1_last = (seg_cnt_reg == tseg1_reg - 1'b1);
  assign tseg2_last = (seg_cnt_reg == tseg2_reg - 1'b1);
  assign in_window  = rate_reg ? (seg_cnt_reg >= tseg1_reg - TQ_W'(3)) : tseg1_last;

  assign presc_restart = (state_reg == IDLE) || hard_sync || !enable;
  assign final_sample  = samplePulse && tseg1_last;

  assign sampledBit = sampled_bit_reg;
  assign bitValid   = bit_valid_reg;
  assign cfgErr     = cfg_err_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_bit) state_next = SYNC;
        end
        SYNC: begin
          if (tq_tick) state_next = TSEG1;
        end
        TSEG1: begin
          if (hard_sync)                    state_next = SYNC;
          else if (tq_tick && tseg1_last)   state_next = TSEG2;
        end
        TSEG2: begin
          if (hard_sync)                    state_next = SYNC;
          else if (tq_tick && tseg2_last)   state_next = SYNC;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A falling edge in the same cycle as a sample point restarts the bit instead.
  always_comb begin
    samplePulse = 1'b0;
    bitStart    = 1'b0;
    if ((state_reg == TSEG1) && enable && tq_tick && in_window && !hard_sync) begin
      samplePulse = 1'b1;
    end
    if ((state_reg == SYNC) && (presc_count == '0)) begin
      bitStart = 1'b1;
    end
  end

  always_comb begin
    seg_cnt_next = seg_cnt_reg;
    if ((state_next != state_reg) || hard_sync) begin
      seg_cnt_next = '0;
    end else if (tq_tick && in_tseg) begin
      seg_cnt_next = seg_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc_reg       <= '0;
      tseg1_reg       <= '0;
      tseg2_reg       <= '0;
      rate_reg        <= 1'b0;
      seg_cnt_reg     <= '0;
      rx_prev_reg     <= 1'b1;
      samples_reg     <= 2'b11;
      sampled_bit_reg <= 1'b1;
      bit_valid_reg   <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      rx_prev_reg   <= rxIn;
      seg_cnt_reg   <= seg_cnt_next;
      bit_valid_reg <= final_sample;

      if (start_bit) begin
        presc_reg <= cfgPresc;
        tseg1_reg <= cfgTseg1;
        tseg2_reg <= cfgTseg2;
        rate_reg  <= rateSelector;
      end

      if (samplePulse) begin
        samples_reg <= {samples_reg[0], rxIn};
      end

      if (final_sample) begin
        sampled_bit_reg <= rate_reg ? majority3(samples_reg[1], samples_reg[0], rxIn) : rxIn;
      end

      if (!enable) begin
        cfg_err_reg <= 1'b0;
      end else if ((state_reg == IDLE) && !cfg_legal) begin
        cfg_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_sample_sched.sv
// Directed bench for bit_sample_sched: table of bit-timing vectors plus
// hand-written hard-sync, enable-drop, illegal-config and async-reset sequences.
module tb_bit_sample_sched;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] cfgPresc = '0;
  logic [4:0] cfgTseg1 = '0;
  logic [4:0] cfgTseg2 = '0;
  logic       rateSelector = 1'b0;
  logic       rxIn = 1'b1;
  logic       busIdle = 1'b0;
  logic       samplePulse, bitStart, sampledBit, bitValid, cfgErr;

  int errors = 0;
  int checks = 0;

  int pulses_q[$];
  int valids_q[$];
  int starts_q[$];
  logic last_bit;

  typedef struct {
    int   presc;
    int   t1;
    int   t2;
    bit   rate;
    logic [2:0] pat;    // pat[k] is driven for the k-th sample
    int   np;
    int   p0;
    int   p1;
    int   p2;
    int   valid_at;
    logic exp_bit;
    int   next_start;
  } vec_t;

  vec_t vecs[7];

  bit_sample_sched #(.PRESC_W(8), .TQ_W(5)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .enable       (enable),
    .cfgPresc     (cfgPresc),
    .cfgTseg1     (cfgTseg1),
    .cfgTseg2     (cfgTseg2),
    .rateSelector (rateSelector),
    .rxIn         (rxIn),
    .busIdle      (busIdle),
    .samplePulse  (samplePulse),
    .bitStart     (bitStart),
    .sampledBit   (sampledBit),
    .bitValid     (bitValid),
    .cfgErr       (cfgErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Configure, enable and wait (bounded) for the first bitStart; that negedge is cycle 0.
  task automatic start_run(input int presc, input int t1, input int t2, input bit rate,
                           input bit idle, output bit ok);
    ok = 1'b0;
    enable = 1'b0;
    rxIn = 1'b1;
    busIdle = idle;
    repeat (3) @(negedge clk);
    cfgPresc = 8'(presc);
    cfgTseg1 = 5'(t1);
    cfgTseg2 = 5'(t2);
    rateSelector = rate;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bitStart) begin
        ok = 1'b1;
        break;
      end
    end
    check("start_timeout", int'(ok), 1);
  endtask

  task automatic observe(input int ncyc, input int fall_at, input int drop_at);
    pulses_q.delete();
    valids_q.delete();
    starts_q.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == fall_at) rxIn = 1'b0;
      if (c == drop_at) enable = 1'b0;
      #1;
      if (samplePulse) pulses_q.push_back(c);
      if (bitValid) begin
        valids_q.push_back(c);
        last_bit = sampledBit;
      end
      if (bitStart) starts_q.push_back(c);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    int k;
    int valid_cnt;
    int valid_cyc;
    int start_cyc;
    logic bit_seen;
    int pulse_cyc[$];
    int exp_p[3];
    exp_p[0] = v.p0;
    exp_p[1] = v.p1;
    exp_p[2] = v.p2;
    k = 0;
    valid_cnt = 0;
    valid_cyc = -1;
    start_cyc = -1;
    bit_seen = 1'bx;
    start_run(v.presc, v.t1, v.t2, v.rate, 1'b0, ok);
    if (!ok) return;
    // These must be ignored until the next IDLE->SYNC transition.
    cfgPresc = 8'd5;
    cfgTseg1 = 5'd9;
    cfgTseg2 = 5'd9;
    rateSelector = ~v.rate;
    for (int c = 1; c <= v.next_start; c++) begin
      @(negedge clk);
      rxIn = v.pat[(k < 3) ? k : 2];
      #1;
      if (samplePulse) begin
        pulse_cyc.push_back(c);
        k++;
      end
      if (bitValid) begin
        valid_cnt++;
        valid_cyc = c;
        bit_seen = sampledBit;
      end
      if (bitStart && start_cyc < 0) start_cyc = c;
    end
    check($sformatf("vec%0d_npulses", idx), pulse_cyc.size(), v.np);
    for (int i = 0; i < v.np; i++)
      check($sformatf("vec%0d_pulse%0d_cycle", idx, i), q_at(pulse_cyc, i), exp_p[3 - v.np + i]);
    check($sformatf("vec%0d_nvalid", idx), valid_cnt, 1);
    check($sformatf("vec%0d_valid_cycle", idx), valid_cyc, v.valid_at);
    check($sformatf("vec%0d_sampledBit", idx), int'(bit_seen), int'(v.exp_bit));
    check($sformatf("vec%0d_next_bitStart", idx), start_cyc, v.next_start);
    $display("vec %0d presc=%0d tseg1=%0d tseg2=%0d rate=%0d: pulses=%0d valid@%0d bit=%0d next@%0d",
             idx, v.presc, v.t1, v.t2, v.rate, pulse_cyc.size(), valid_cyc, bit_seen, start_cyc);
  endtask

  initial begin
    bit ok;
    int cnt_p;
    int cnt_s;

    // presc t1 t2 rate pat np p0 p1 p2 valid bit next
    vecs[0] = '{1, 5, 2, 1'b1, 3'b010, 3,  7,  9, 11, 12, 1'b0, 16};
    vecs[1] = '{1, 5, 2, 1'b0, 3'b001, 1, -1, -1, 11, 12, 1'b1, 16};
    vecs[2] = '{1, 5, 2, 1'b1, 3'b101, 3,  7,  9, 11, 12, 1'b1, 16};
    vecs[3] = '{0, 3, 1, 1'b1, 3'b011, 3,  1,  2,  3,  4, 1'b1,  5};
    vecs[4] = '{2, 4, 3, 1'b1, 3'b100, 3,  8, 11, 14, 15, 1'b0, 24};
    vecs[5] = '{3, 1, 1, 1'b0, 3'b000, 1, -1, -1,  7,  8, 1'b0, 12};
    vecs[6] = '{0, 31, 31, 1'b1, 3'b001, 3, 29, 30, 31, 32, 1'b0, 63};

    #2 resetN = 1'b0;
    #1;
    check("reset_samplePulse", int'(samplePulse), 0);
    check("reset_bitStart", int'(bitStart), 0);
    check("reset_bitValid", int'(bitValid), 0);
    check("reset_cfgErr", int'(cfgErr), 0);
    check("reset_sampledBit", int'(sampledBit), 1);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    $display("reset released");

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Hard sync in TSEG1 at cycle 5: new bit from cycle 6, aborted bit yields no bitValid.
    start_run(1, 5, 2, 1'b1, 1'b1, ok);
    observe(20, 5, -1);
    check("hs_nstarts", starts_q.size(), 1);
    check("hs_start_cycle", q_at(starts_q, 0), 6);
    check("hs_npulses", pulses_q.size(), 3);
    check("hs_pulse0", q_at(pulses_q, 0), 13);
    check("hs_pulse1", q_at(pulses_q, 1), 15);
    check("hs_pulse2", q_at(pulses_q, 2), 17);
    check("hs_nvalid", valids_q.size(), 1);
    check("hs_valid_cycle", q_at(valids_q, 0), 18);
    check("hs_sampledBit", int'(last_bit), 0);
    $display("hard sync @5: start@%0d pulses=%0d valids=%0d", q_at(starts_q, 0), pulses_q.size(), valids_q.size());

    // Falling edge on the first sample cycle: the sample is suppressed.
    start_run(1, 5, 2, 1'b1, 1'b1, ok);
    observe(21, 7, -1);
    check("hsco_start_cycle", q_at(starts_q, 0), 8);
    check("hsco_npulses", pulses_q.size(), 3);
    check("hsco_pulse0", q_at(pulses_q, 0), 15);
    check("hsco_pulse2", q_at(pulses_q, 2), 19);
    check("hsco_valid_cycle", q_at(valids_q, 0), 20);
    check("hsco_nvalid", valids_q.size(), 1);
    $display("hard sync on sample @7: start@%0d first pulse@%0d", q_at(starts_q, 0), q_at(pulses_q, 0));

    // enable drops at cycle 8, after the first sample only.
    start_run(1, 5, 2, 1'b1, 1'b0, ok);
    observe(30, -1, 8);
    check("endrop_npulses", pulses_q.size(), 1);
    check("endrop_pulse0", q_at(pulses_q, 0), 7);
    check("endrop_nvalid", valids_q.size(), 0);
    check("endrop_nstarts", starts_q.size(), 0);
    $display("enable drop @8: pulses=%0d valids=%0d", pulses_q.size(), valids_q.size());

    // Illegal configurations latch cfgErr and never start.
    for (int j = 0; j < 3; j++) begin
      enable = 1'b0;
      repeat (2) @(negedge clk);
      cfgPresc = 8'd1;
      cfgTseg1 = (j == 0) ? 5'd2 : (j == 1) ? 5'd5 : 5'd0;
      cfgTseg2 = (j == 1) ? 5'd0 : 5'd3;
      rateSelector = (j == 0);
      enable = 1'b1;
      cnt_p = 0;
      cnt_s = 0;
      for (int c = 0; c < ((j == 0) ? 100 : 10); c++) begin
        @(negedge clk);
        #1;
        if (samplePulse) cnt_p++;
        if (bitStart) cnt_s++;
      end
      check($sformatf("cfgerr%0d_set", j), int'(cfgErr), 1);
      check($sformatf("cfgerr%0d_pulses", j), cnt_p, 0);
      check($sformatf("cfgerr%0d_starts", j), cnt_s, 0);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      #1;
      check($sformatf("cfgerr%0d_clear", j), int'(cfgErr), 0);
      $display("illegal cfg %0d: cfgErr latched, pulses=%0d starts=%0d", j, cnt_p, cnt_s);
    end

    // Async reset at cycle 9 of the second bit, after a dominant bit was voted.
    start_run(1, 5, 2, 1'b1, 1'b0, ok);
    observe(24, 1, -1);
    check("rst_pre_valid_cycle", q_at(valids_q, 0), 12);
    check("rst_pre_start", q_at(starts_q, 0), 16);
    check("rst_pre_sampledBit", int'(sampledBit), 0);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("rst_mid_samplePulse", int'(samplePulse), 0);
    check("rst_mid_bitStart", int'(bitStart), 0);
    check("rst_mid_bitValid", int'(bitValid), 0);
    check("rst_mid_cfgErr", int'(cfgErr), 0);
    check("rst_mid_sampledBit", int'(sampledBit), 1);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    #1;
    check("rst_release_bitStart", int'(bitStart), 1);
    $display("async reset mid-bit: sampledBit=%0d after release bitStart=%0d", sampledBit, bitStart);

    enable = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_sample_sched.md
BIT_SAMPLE_SCHED -- requirements
Module: bit_sample_sched

Interface
REQ-001 SHALL have parameter PRESC_W, default 8, meaning prescaler width.
REQ-002 SHALL have parameter TQ_W, default 5, meaning time-quantum segment counter width.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  run request; low forces IDLE.
REQ-006 cfgPresc  input  PRESC_W  clocks per quantum minus 1.
REQ-007 cfgTseg1  input  TQ_W  quanta in segment 1; sample point is at its end.
REQ-008 cfgTseg2  input  TQ_W  quanta in segment 2.
REQ-009 rateSelector  input  1  1 = three sample points, 0 = one.
REQ-010 rxIn  input  1  synchronised bus bit (0 = dominant).
REQ-011 busIdle  input  1  hard-sync permitted (driven from the error/idle tracker).
REQ-012 samplePulse  output  1  one-cycle sample strobe to the error detector.
REQ-013 bitStart  output  1  one-cycle pulse on first clock of each bit.
REQ-014 sampledBit  output  1  voted bit value.
REQ-015 bitValid  output  1  one-cycle pulse qualifying sampledBit.
REQ-016 cfgErr  output  1  latched illegal configuration.

Function
REQ-017 SHALL generate tqTick, high on the last clock of each quantum (every cfgPresc+1 clocks); tqTick is 1 on every clock when cfgPresc=0.
REQ-018 SHALL use states IDLE, SYNC (1 tq), TSEG1 (cfgTseg1 tq), TSEG2 (cfgTseg2 tq); transitions only on tqTick: SYNC->TSEG1->TSEG2->SYNC.
REQ-019 SHALL latch cfgPresc/cfgTseg1/cfgTseg2/rateSelector on the IDLE->SYNC transition; input changes while running SHALL be ignored.
REQ-020 SHALL leave IDLE when enable=1 and config legal; first clock in SYNC asserts bitStart.
REQ-021 Config illegal: cfgTseg2=0, cfgTseg1=0, or cfgTseg1<3 with rateSelector=1; SHALL set cfgErr, stay IDLE, clear cfgErr only when enable=0.
REQ-022 rateSelector=1: samplePulse SHALL assert on tqTick ending TSEG1 quanta cfgTseg1-2, cfgTseg1-1, cfgTseg1; rateSelector=0: only the last.
REQ-023 rxIn SHALL be captured at each samplePulse; sampledBit = majority of three (or the single sample); bitValid and updated sampledBit SHALL appear the clock after the final samplePulse.
REQ-024 Hard sync: rxIn falling edge (registered prev=1, now=0) with busIdle=1 in TSEG1 or TSEG2 SHALL reset prescaler to 0 and enter SYNC, bitStart asserted; partial samples discarded, no bitValid for the aborted bit.
REQ-025 Edge coincident with a samplePulse cycle: hard sync wins, samplePulse suppressed.
REQ-026 enable falling mid-bit SHALL go to IDLE next clock, no further samplePulse/bitValid.
REQ-027 Segment counter SHALL not wrap: maximum cfgTseg values (2^TQ_W-1) SHALL time correctly.

Reset
REQ-028 On resetN=0: state IDLE, counters 0, samplePulse/bitStart/bitValid/cfgErr 0, sampledBit 1 (recessive), edge register 1.
REQ-029 Reset SHALL take effect asynchronously mid-bit; release synchronous to clk.

Structure
REQ-030 State enum (IDLE/SYNC/TSEG1/TSEG2) and PRESC_W/TQ_W defaults SHALL live in a shared package ch_timing_pkg.
REQ-031 Prescaler SHALL be a separate sub-module tq_prescaler (count, tqTick, synchronous restart input).

Verification
REQ-032 cfgPresc=1, cfgTseg1=5, cfgTseg2=2, rate=1, bit start at cycle 0 -> samplePulse at cycles 7, 9, 11; bitValid at 12; next bitStart at 16.
REQ-033 Same config, rate=0 -> single samplePulse at cycle 11; bitValid at 12.
REQ-034 rate=1, samples rxIn 0,1,0 -> sampledBit=0; samples 1,0,1 -> sampledBit=1.
REQ-035 busIdle=1, rxIn 1->0 at cycle 5 of a bit -> bitStart cycle 6, then samplePulse at 13, 15, 17; no bitValid for aborted bit.
REQ-036 cfgTseg1=2, rate=1, enable=1 -> cfgErr=1, no samplePulse for 100 cycles; enable=0 clears cfgErr.
REQ-037 resetN low at cycle 9 of a running bit -> all outputs at reset values same cycle, sampledBit=1.
